// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR unit: CSR addresses, bit indices,
// SYSTEM funct12 encodings and the trap-sequencer state enum.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MIP     = 12'h344;

`ifdef CSR_COUNTER_EN
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
`endif

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;
  localparam logic [1:0] MSTATUS_MPP_M = 2'b11;

  // Op code 000 from the ALU control decoder marks the SYSTEM MRET/WFI group.
  localparam logic [2:0]  CSR_OP_SYS = 3'b000;
  localparam logic [11:0] F12_MRET   = 12'h302;
  localparam logic [11:0] F12_WFI    = 12'h105;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WFI  = 2'd1,
    ST_TRAP = 2'd2
  } csr_state_e;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with increment enable and independent 32-bit half writes.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] cnt_q, cnt_d;

  // A write to either half suppresses the increment for that whole cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cnt_d[31:0]  = wdata_i;
      if (wr_hi_i) cnt_d[63:32] = wdata_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap sequencer (RUN/WFI/TRAP) at the EX stage.
// Define CSR_COUNTER_EN to add mcycle/minstret counters and their read-only shadows.
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0001_0000,
  parameter int          XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_valid,
  input  logic [2:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      zimm,
  input  logic [XLEN-1:0] pc_ex,
  input  logic            instr_retire,
  input  logic            ext_irq,
  input  logic            timer_irq,
  output logic [XLEN-1:0] csr_rdata,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  csr_state_e      state_q, state_d;
  logic            mie_bit_q, mie_bit_d, mpie_q, mpie_d;
  logic            mtie_q, mtie_d, meie_q, meie_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mtvec_q, mtvec_d;
  logic [XLEN-1:0] mstatus_v, mie_v, mip_v, old_v, src, wdata, redir_pc;
  logic            is_csr, is_mret, is_wfi, irq_any, irq_pend;
  logic            do_write, take_trap, do_mret, redir;
`ifdef CSR_COUNTER_EN
  logic [63:0]     mcycle, minstret;
`endif

  always_comb begin
    mstatus_v = '0;
    mstatus_v[12:11] = MSTATUS_MPP_M;
    mstatus_v[MSTATUS_MIE]  = mie_bit_q;
    mstatus_v[MSTATUS_MPIE] = mpie_q;
    mie_v = '0;
    mie_v[MIE_MTIE] = mtie_q;
    mie_v[MIE_MEIE] = meie_q;
    mip_v = '0;
    mip_v[MIE_MTIE] = timer_irq;
    mip_v[MIE_MEIE] = ext_irq;
  end

  assign irq_any  = |(mie_v & mip_v);
  assign irq_pend = mie_bit_q & irq_any;

  always_comb begin
    old_v = '0;
    case (csr_addr)
      CSR_MSTATUS: old_v = mstatus_v;
      CSR_MIE:     old_v = mie_v;
      CSR_MIP:     old_v = mip_v;
      CSR_MEPC:    old_v = mepc_q;
      CSR_MTVEC:   old_v = mtvec_q;
`ifdef CSR_COUNTER_EN
      CSR_MCYCLE,    CSR_CYCLE:    old_v = mcycle[31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   old_v = mcycle[63:32];
      CSR_MINSTRET,  CSR_INSTRET:  old_v = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: old_v = minstret[63:32];
`endif
      default:     old_v = '0;
    endcase
  end

  assign is_csr  = csr_valid && (csr_op != CSR_OP_SYS);
  assign is_mret = csr_valid && (csr_op == CSR_OP_SYS) && (csr_addr == F12_MRET);
  assign is_wfi  = csr_valid && (csr_op == CSR_OP_SYS) && (csr_addr == F12_WFI);
  assign src     = csr_op[2] ? {{(XLEN-5){1'b0}}, zimm} : rs1_data;

  always_comb begin
    case (csr_op[1:0])
      2'b01:   wdata = src;
      2'b10:   wdata = old_v | src;
      2'b11:   wdata = old_v & ~src;
      default: wdata = old_v;
    endcase
  end

  // Set/clear with a zero source is a pure read; a pending interrupt squashes the op.
  assign do_write = is_csr && (state_q == ST_RUN) && !irq_pend &&
                    (csr_op[1:0] != 2'b00) && !(csr_op[1] && (src == '0));

  always_comb begin
    state_d   = state_q;
    take_trap = 1'b0;
    do_mret   = 1'b0;
    redir     = 1'b0;
    redir_pc  = '0;
    case (state_q)
      ST_RUN: begin
        if (irq_pend) begin
          state_d   = ST_TRAP;
          take_trap = 1'b1;
        end else if (is_mret) begin
          do_mret  = 1'b1;
          redir    = 1'b1;
          redir_pc = mepc_q;
        end else if (is_wfi) begin
          state_d = ST_WFI;
        end
      end
      ST_WFI: begin
        if (irq_any) begin
          if (mie_bit_q) begin
            state_d   = ST_TRAP;
            take_trap = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_TRAP: begin
        state_d  = ST_RUN;
        redir    = 1'b1;
        redir_pc = mtvec_q;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    mie_bit_d = mie_bit_q;
    mpie_d    = mpie_q;
    mtie_d    = mtie_q;
    meie_d    = meie_q;
    mepc_d    = mepc_q;
    mtvec_d   = mtvec_q;
    if (take_trap) begin
      mepc_d    = pc_ex & ALIGN_MASK;
      mpie_d    = mie_bit_q;
      mie_bit_d = 1'b0;
    end else if (do_mret) begin
      mie_bit_d = mpie_q;
      mpie_d    = 1'b1;
    end else if (do_write) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_bit_d = wdata[MSTATUS_MIE];
          mpie_d    = wdata[MSTATUS_MPIE];
        end
        CSR_MIE: begin
          mtie_d = wdata[MIE_MTIE];
          meie_d = wdata[MIE_MEIE];
        end
        CSR_MEPC:  mepc_d  = wdata & ALIGN_MASK;
        CSR_MTVEC: mtvec_d = wdata & ALIGN_MASK;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      mie_bit_q <= 1'b0;
      mpie_q    <= 1'b0;
      mtie_q    <= 1'b0;
      meie_q    <= 1'b0;
      mepc_q    <= '0;
      mtvec_q   <= MTVEC_RESET & ALIGN_MASK;
    end else begin
      state_q   <= state_d;
      mie_bit_q <= mie_bit_d;
      mpie_q    <= mpie_d;
      mtie_q    <= mtie_d;
      meie_q    <= meie_d;
      mepc_q    <= mepc_d;
      mtvec_q   <= mtvec_d;
    end
  end

`ifdef CSR_COUNTER_EN
  csr_counter64 u_mcycle (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (1'b1),
    .wr_lo_i (do_write && (csr_addr == CSR_MCYCLE)),
    .wr_hi_i (do_write && (csr_addr == CSR_MCYCLEH)),
    .wdata_i (wdata),
    .count_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (instr_retire),
    .wr_lo_i (do_write && (csr_addr == CSR_MINSTRET)),
    .wr_hi_i (do_write && (csr_addr == CSR_MINSTRETH)),
    .wdata_i (wdata),
    .count_o (minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
`endif

  // Outputs are held quiet while reset is asserted, so a pending TRAP never redirects.
  assign csr_rdata      = (csr_valid && !rst) ? old_v : '0;
  assign stall          = (state_q == ST_WFI) && !rst;
  assign redirect_valid = redir && !rst;
  assign redirect_pc    = (redir && !rst) ? redir_pc : '0;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: expected rdata/redirects queued by the driver,
// consumed by a negedge monitor; stall and reset values checked inline.
module tb_csr_unit;

  localparam logic [2:0] OP_SYS = 3'b000, OP_RW = 3'b001, OP_RS = 3'b010, OP_RC = 3'b011;
  localparam logic [2:0] OP_RSI = 3'b110;

  logic        clk, rst, csr_valid, instr_retire, ext_irq, timer_irq;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data, pc_ex, csr_rdata, redirect_pc;
  logic [4:0]  zimm;
  logic        stall, redirect_valid;

  // bit 32 set = don't-care entry
  logic [32:0] exp_q[$];
  logic [31:0] exp_redir_q[$];
  logic [32:0] mon_e;
  logic [31:0] mon_r;
  int checks = 0;
  int failures = 0;

  csr_unit dut (
    .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .rs1_data(rs1_data), .zimm(zimm), .pc_ex(pc_ex), .instr_retire(instr_retire),
    .ext_irq(ext_irq), .timer_irq(timer_irq), .csr_rdata(csr_rdata), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (csr_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rdata_unexpected: addr=%h got %h, no expectation queued", csr_addr, csr_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (!mon_e[32]) begin
          checks++;
          if (csr_rdata !== mon_e[31:0]) begin
            failures++;
            $display("FAIL rdata addr=%h: got %h expected %h", csr_addr, csr_rdata, mon_e[31:0]);
          end
        end
      end
    end
    if (redirect_valid) begin
      checks++;
      if (exp_redir_q.size() == 0) begin
        failures++;
        $display("FAIL redirect_unexpected: pc=%h, none expected", redirect_pc);
      end else begin
        mon_r = exp_redir_q.pop_front();
        if (redirect_pc !== mon_r) begin
          failures++;
          $display("FAIL redirect_pc: got %h expected %h", redirect_pc, mon_r);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_stall(input logic exp);
    @(negedge clk);
    check_eq("stall", {31'b0, stall}, {31'b0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic csr_cmd(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] rs1,
                         input logic [4:0] z, input logic [32:0] exp);
    csr_valid = 1'b1; csr_op = op; csr_addr = addr; rs1_data = rs1; zimm = z;
    exp_q.push_back(exp);
    tick();
    csr_valid = 1'b0; csr_op = 3'b0; csr_addr = 12'h0; rs1_data = '0; zimm = '0;
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp);
    csr_cmd(OP_RS, addr, 32'h0, 5'd0, {1'b0, exp});
  endtask

  initial begin
    rst = 1'b1; csr_valid = 1'b0; csr_op = '0; csr_addr = '0; rs1_data = '0; zimm = '0;
    pc_ex = 32'h0; instr_retire = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0;
    tick();
    @(negedge clk);
    check_eq("reset_rdata", csr_rdata, 32'h0);
    check_eq("reset_stall", {31'b0, stall}, 32'h0);
    check_eq("reset_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    check_eq("reset_redirect_pc", redirect_pc, 32'h0);
    tick();
    rst = 1'b0;

    // mtvec write with low bits forced clear
    csr_cmd(OP_RW, 12'h305, 32'h0000_2003, 5'd0, {1'b0, 32'h0001_0000});
    rd(12'h305, 32'h0000_2000);

    // zero-source set is a read only; then set MTIE|MEIE
    csr_cmd(OP_RSI, 12'h304, 32'h0, 5'd0, {1'b0, 32'h0});
    rd(12'h304, 32'h0);
    csr_cmd(OP_RS, 12'h304, 32'h0000_0880, 5'd0, {1'b0, 32'h0});
    rd(12'h304, 32'h0000_0880);
    rd(12'h344, 32'h0);

    csr_cmd(OP_RS, 12'h300, 32'h8, 5'd0, {1'b0, 32'h0000_1800});
    rd(12'h300, 32'h0000_1808);

    // interrupt beats a CSRRW in EX
    ext_irq = 1'b1; pc_ex = 32'h0000_0100;
    exp_redir_q.push_back(32'h0000_2000);
    csr_cmd(OP_RW, 12'h305, 32'hDEAD_0000, 5'd0, {1'b0, 32'h0000_2000});
    ext_irq = 1'b0;
    tick();
    rd(12'h341, 32'h0000_0100);
    rd(12'h300, 32'h0000_1880);
    rd(12'h305, 32'h0000_2000);

    // MRET: same-cycle redirect to mepc, MIE restored
    exp_redir_q.push_back(32'h0000_0100);
    csr_cmd(OP_SYS, 12'h302, 32'h0, 5'd0, {1'b0, 32'h0});
    rd(12'h300, 32'h0000_1888);

    // WFI with MIE clear, woken by the timer without a redirect
    csr_cmd(OP_RC, 12'h300, 32'h8, 5'd0, {1'b0, 32'h0000_1888});
    rd(12'h300, 32'h0000_1880);
    csr_cmd(OP_SYS, 12'h105, 32'h0, 5'd0, {1'b0, 32'h0});
    for (int i = 0; i < 5; i++) check_stall(1'b1);
    timer_irq = 1'b1;
    check_stall(1'b1);
    check_stall(1'b0);
    rd(12'h344, 32'h0000_0080);
    timer_irq = 1'b0;

    csr_cmd(OP_RW, 12'h7C0, 32'hFFFF_FFFF, 5'd0, {1'b0, 32'h0});
    rd(12'h7C0, 32'h0);
    csr_cmd(OP_RW, 12'h341, 32'h0000_0123, 5'd0, {1'b0, 32'h0000_0100});
    rd(12'h341, 32'h0000_0120);

    // reset while in WFI
    csr_cmd(OP_SYS, 12'h105, 32'h0, 5'd0, {1'b0, 32'h0});
    check_stall(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_stall(1'b0);
    rd(12'h300, 32'h0000_1800);

    // reset while in TRAP: no redirect may appear
    csr_cmd(OP_RW, 12'h304, 32'h0000_0800, 5'd0, {1'b0, 32'h0});
    csr_cmd(OP_RS, 12'h300, 32'h8, 5'd0, {1'b0, 32'h0000_1800});
    ext_irq = 1'b1;
    tick();
    rst = 1'b1; ext_irq = 1'b0;
    tick();
    rst = 1'b0;
    check_stall(1'b0);
    rd(12'h300, 32'h0000_1800);
    rd(12'h341, 32'h0);

`ifdef CSR_COUNTER_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd(12'hB00, 32'h0);
    rd(12'hC80, 32'h0);
    instr_retire = 1'b1;
    tick(); tick(); tick();
    instr_retire = 1'b0;
    rd(12'hB02, 32'h3);
    rd(12'hC82, 32'h0);
    csr_cmd(OP_RW, 12'hB00, 32'hFFFF_FFFF, 5'd0, {1'b1, 32'h0});
    csr_cmd(OP_RW, 12'hB80, 32'h0, 5'd0, {1'b0, 32'h0});
    rd(12'hB00, 32'hFFFF_FFFF);
    rd(12'hB80, 32'h1);
    rd(12'hC00, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd(12'hB00, 32'h0);
    rd(12'hB80, 32'h0);
`else
    csr_cmd(OP_RW, 12'hB00, 32'h5, 5'd0, {1'b0, 32'h0});
    rd(12'hB00, 32'h0);
    rd(12'hC02, 32'h0);
    rd(12'hB82, 32'h0);
`endif

    tick(); tick();
    check_eq("rdata_queue_drained", exp_q.size(), 32'h0);
    check_eq("redirect_queue_drained", exp_redir_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
